// File: rtl/datamem_port_sched.sv
// Word-port sequencer/arbiter for the AES data memory: CPU scalar/vector and host load/unload.
// Optional macro DMEM_HOST_PRIO_EN gives the host fixed priority instead of round-robin.
module datamem_port_sched #(
  parameter int AW    = 7,
  parameter int DEPTH = 70
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_vec,
  input  logic [127:0]  cpu_addr,
  input  logic [127:0]  cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [127:0]  cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [31:0]   host_addr,
  input  logic [31:0]   host_wdata,
  output logic          host_done,
  output logic [31:0]   host_rdata,
  output logic          addr_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t       state_q;
  logic [1:0]   lane_q;
  logic         host_own_q;
  logic         last_host_q;
  logic         we_q;
  logic         vec_q;
  logic         err_q;
  logic [29:0]  word_q  [4];
  logic [31:0]  wdata_q [4];
  logic         cpu_gnt_q;
  logic         cpu_done_q;
  logic         host_done_q;
  logic         addr_err_q;
  logic [127:0] cpu_rdata_q;
  logic [31:0]  host_rdata_q;

  logic [29:0]  cpu_word  [4];
  logic [31:0]  cpu_wlane [4];
  logic [3:0]   unused_cpu_lsb;
  logic         unused_host_lsb;

  // Byte-address bits [1:0] are dropped: every access is word-aligned.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign cpu_word[gi]       = cpu_addr[32*gi+2 +: 30];
    assign cpu_wlane[gi]      = cpu_wdata[32*gi +: 32];
    assign unused_cpu_lsb[gi] = ^cpu_addr[32*gi +: 2];
  end
  assign unused_host_lsb = ^host_addr[1:0];

  logic [29:0] lane_word;
  logic        lane_ok;
  logic        access;
  logic        last_lane;
  logic        err_d;
  logic [31:0] rd_val;
  logic        grant_host;

  assign lane_word = word_q[lane_q];
  assign lane_ok   = lane_word < 30'(DEPTH);
  assign access    = (state_q == S_ACCESS);
  assign last_lane = host_own_q || !vec_q || (lane_q == 2'd3);
  assign err_d     = err_q | ~lane_ok;
  assign rd_val    = lane_ok ? mem_rdata : 32'h0;

`ifdef DMEM_HOST_PRIO_EN
  logic unused_last_host;
  assign unused_last_host = last_host_q;
  assign grant_host = host_req;
`else
  // On a tie the requester that did not win last time is served.
  assign grant_host = host_req & (~cpu_req | ~last_host_q);
`endif

  assign mem_en    = access;
  assign mem_we    = access & we_q & lane_ok;
  assign mem_addr  = access ? lane_word[AW-1:0] : '0;
  assign mem_wdata = access ? wdata_q[lane_q] : 32'h0;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= S_IDLE;
      lane_q       <= 2'd0;
      host_own_q   <= 1'b0;
      last_host_q  <= 1'b1;
      we_q         <= 1'b0;
      vec_q        <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        word_q[i]  <= '0;
        wdata_q[i] <= '0;
      end
      cpu_gnt_q    <= 1'b0;
      cpu_done_q   <= 1'b0;
      host_done_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      cpu_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      host_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req || host_req) begin
            state_q     <= S_ACCESS;
            lane_q      <= 2'd0;
            err_q       <= 1'b0;
            host_own_q  <= grant_host;
            last_host_q <= grant_host;
            if (grant_host) begin
              we_q       <= host_we;
              vec_q      <= 1'b0;
              word_q[0]  <= host_addr[31:2];
              wdata_q[0] <= host_wdata;
              if (!host_we) host_rdata_q <= '0;
            end else begin
              we_q      <= cpu_we;
              vec_q     <= cpu_vec;
              cpu_gnt_q <= 1'b1;
              for (int i = 0; i < 4; i++) begin
                word_q[i]  <= cpu_word[i];
                wdata_q[i] <= cpu_wlane[i];
              end
              if (!cpu_we) cpu_rdata_q <= '0;
            end
          end
        end
        S_ACCESS: begin
          err_q <= err_d;
          if (!we_q) begin
            if (host_own_q) host_rdata_q <= rd_val;
            else            cpu_rdata_q[{lane_q, 5'd0} +: 32] <= rd_val;
          end
          if (last_lane) begin
            state_q     <= S_DONE;
            cpu_done_q  <= ~host_own_q;
            host_done_q <= host_own_q;
            addr_err_q  <= err_d;
          end else begin
            lane_q <= lane_q + 2'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign cpu_done   = cpu_done_q;
  assign host_done  = host_done_q;
  assign addr_err   = addr_err_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
endmodule
